// File: rtl/csr_mgr_pkg.sv
// Shared constants for the accelerator CSR endpoint.
// CTRL and BUSYCNT sit directly after the RW and RO windows.
// CTRL read layout: bit0 busy, bit1 done_sticky; write bit0 starts a run.
package csr_mgr_pkg;

  localparam int BUSY_BIT  = 0;
  localparam int DONE_BIT  = 1;
  localparam int START_BIT = 0;

  function automatic int ctrl_addr(input int num_rw, input int num_ro);
    return num_rw + num_ro;
  endfunction

  function automatic int busycnt_addr(input int num_rw, input int num_ro);
    return num_rw + num_ro + 1;
  endfunction

endpackage

// File: rtl/csr_sat_counter.sv
// Saturating up-counter with synchronous clear (clear has priority).
// Latency: count visible one cycle after inc/clr.
// Backpressure: none; holds at all-ones once saturated.
module csr_sat_counter #(
  parameter int Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q;

  // Count up on inc, stop at all-ones, clear on request
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + Width'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/csr_reg_manager.sv
// Accelerator CSR endpoint: RW config regs, RO status, CTRL (start/busy/done), busy-cycle counter.
// Latency: read response one cycle after accept; writes visible one cycle after accept.
// Backpressure: one request outstanding; ready low while a response waits, writes stall while busy.
module csr_reg_manager
  import csr_mgr_pkg::*;
#(
  parameter int  NumRwCsr      = 4,
  parameter int  NumRoCsr      = 2,
  parameter int  RegDataWidth  = 32,
  localparam int TotalRegCount = NumRwCsr + NumRoCsr + 2,
  localparam int RegAddrWidth  = $clog2(TotalRegCount)
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [RegAddrWidth-1:0]                csr_addr_i,
  input  logic [RegDataWidth-1:0]                csr_wr_data_i,
  input  logic                                   csr_wr_en_i,
  input  logic                                   csr_req_valid_i,
  output logic                                   csr_req_ready_o,
  output logic [RegDataWidth-1:0]                csr_rd_data_o,
  output logic                                   csr_rsp_valid_o,
  input  logic                                   csr_rsp_ready_i,
  output logic [NumRwCsr-1:0][RegDataWidth-1:0]  csr_reg_rw_set_o,
  input  logic [NumRoCsr-1:0][RegDataWidth-1:0]  csr_reg_ro_set_i,
  output logic                                   acc_start_o,
  input  logic                                   acc_busy_i,
  input  logic                                   acc_done_i
);

  localparam logic [RegAddrWidth-1:0] CtrlAddr    = RegAddrWidth'(ctrl_addr(NumRwCsr, NumRoCsr));
  localparam logic [RegAddrWidth-1:0] BusyCntAddr = RegAddrWidth'(busycnt_addr(NumRwCsr, NumRoCsr));

  logic [NumRwCsr-1:0][RegDataWidth-1:0] rw_q;
  logic [RegDataWidth-1:0]               rd_data_q;
  logic [RegDataWidth-1:0]               rd_next;
  logic [RegDataWidth-1:0]               busy_cnt;
  logic                                  rsp_valid_q;
  logic                                  start_q;
  logic                                  start_pulse_q;
  logic                                  done_q;
  logic                                  busy;
  logic                                  accept;
  logic                                  wr_acc;
  logic                                  rd_acc;
  logic                                  is_ctrl;
  logic                                  start_wr;
  logic                                  ctrl_rd;

  // start_q bridges the gap between the start write and the accelerator raising busy
  assign busy            = acc_busy_i | start_q;
  assign csr_req_ready_o = !rsp_valid_q && !(csr_wr_en_i && busy);
  assign accept          = csr_req_valid_i && csr_req_ready_o;
  assign wr_acc          = accept && csr_wr_en_i;
  assign rd_acc          = accept && !csr_wr_en_i;
  assign is_ctrl         = (csr_addr_i == CtrlAddr);
  assign start_wr        = wr_acc && is_ctrl && csr_wr_data_i[START_BIT];
  assign ctrl_rd         = rd_acc && is_ctrl;

  // Read data mux; unmapped addresses fall through to zero
  always_comb begin
    rd_next = '0;
    for (int i = 0; i < NumRwCsr; i++) begin
      if (csr_addr_i == RegAddrWidth'(i)) rd_next = rw_q[i];
    end
    for (int j = 0; j < NumRoCsr; j++) begin
      if (csr_addr_i == RegAddrWidth'(NumRwCsr + j)) rd_next = csr_reg_ro_set_i[j];
    end
    if (is_ctrl) begin
      rd_next[BUSY_BIT] = busy;
      rd_next[DONE_BIT] = done_q;
    end
    if (csr_addr_i == BusyCntAddr) rd_next = busy_cnt;
  end

  // Configuration register writes; other addresses ignore write data
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rw_q <= '0;
    end else begin
      for (int i = 0; i < NumRwCsr; i++) begin
        if (wr_acc && (csr_addr_i == RegAddrWidth'(i))) rw_q[i] <= csr_wr_data_i;
      end
    end
  end

  // Read response: capture on accept, hold data stable until the consumer takes it
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rsp_valid_q <= 1'b0;
      rd_data_q   <= '0;
    end else if (rd_acc) begin
      rsp_valid_q <= 1'b1;
      rd_data_q   <= rd_next;
    end else if (rsp_valid_q && csr_rsp_ready_i) begin
      rsp_valid_q <= 1'b0;
    end
  end

  // Start pulse, pending-start flag and sticky done (a new done beats a clearing read)
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      start_q       <= 1'b0;
      start_pulse_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      start_pulse_q <= start_wr;
      if (start_wr) begin
        start_q <= 1'b1;
      end else if (acc_busy_i) begin
        start_q <= 1'b0;
      end
      if (acc_done_i) begin
        done_q <= 1'b1;
      end else if (ctrl_rd) begin
        done_q <= 1'b0;
      end
    end
  end

  csr_sat_counter #(
    .Width (RegDataWidth)
  ) u_busy_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (acc_busy_i),
    .clr_i   (start_wr),
    .count_o (busy_cnt)
  );

  assign csr_rd_data_o    = rd_data_q;
  assign csr_rsp_valid_o  = rsp_valid_q;
  assign csr_reg_rw_set_o = rw_q;
  assign acc_start_o      = start_pulse_q;

endmodule

// File: tb/tb_csr_reg_manager.sv
// Directed bench for csr_reg_manager with three RO registers so out-of-range addresses exist.
// Map: RW 0..3, RO 4..6, CTRL 7, BUSYCNT 8, out-of-range 9..15.
// Inputs change 1ns after a rising edge; outputs are sampled there too.
module tb_csr_reg_manager;

  localparam int NRW  = 4;
  localparam int NRO  = 3;
  localparam int DW   = 32;
  localparam int AW   = 4;
  localparam logic [AW-1:0] CTRL = 4'd7;
  localparam logic [AW-1:0] BCNT = 4'd8;
  localparam logic [AW-1:0] TOT  = 4'd9;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [AW-1:0]           addr;
  logic [DW-1:0]           wdata;
  logic                    wr_en;
  logic                    req_valid;
  logic                    req_ready;
  logic [DW-1:0]           rd_data;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [NRW-1:0][DW-1:0]  rw_set;
  logic [NRO-1:0][DW-1:0]  ro_set;
  logic                    acc_start;
  logic                    acc_busy;
  logic                    acc_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  csr_reg_manager #(
    .NumRwCsr     (NRW),
    .NumRoCsr     (NRO),
    .RegDataWidth (DW)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .csr_addr_i       (addr),
    .csr_wr_data_i    (wdata),
    .csr_wr_en_i      (wr_en),
    .csr_req_valid_i  (req_valid),
    .csr_req_ready_o  (req_ready),
    .csr_rd_data_o    (rd_data),
    .csr_rsp_valid_o  (rsp_valid),
    .csr_rsp_ready_i  (rsp_ready),
    .csr_reg_rw_set_o (rw_set),
    .csr_reg_ro_set_i (ro_set),
    .acc_start_o      (acc_start),
    .acc_busy_i       (acc_busy),
    .acc_done_i       (acc_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for ready with the request already driven
  task automatic wait_ready(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (req_ready) break;
      @(posedge clk); #1;
    end
    chk(tag, 32'(req_ready), 32'd1);
  endtask

  // Returns 1ns after the cycle following the accept edge
  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    addr = a; wdata = d; wr_en = 1'b1; req_valid = 1'b1;
    #1;
    wait_ready("wr_ready");
    @(posedge clk); #1;
    req_valid = 1'b0; wr_en = 1'b0;
  endtask

  // Read with response ready; optionally pulse acc_done on the accept edge
  task automatic rd(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp,
                    input bit done_at_accept);
    addr = a; wr_en = 1'b0; req_valid = 1'b1; rsp_ready = 1'b1;
    if (done_at_accept) acc_done = 1'b1;
    #1;
    wait_ready("rd_ready");
    @(posedge clk); #1;
    req_valid = 1'b0; acc_done = 1'b0;
    chk({tag, "_vld"}, 32'(rsp_valid), 32'd1);
    chk(tag, rd_data, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; addr = '0; wdata = '0; wr_en = 1'b0; req_valid = 1'b0;
    rsp_ready = 1'b1; acc_busy = 1'b0; acc_done = 1'b0;
    ro_set[0] = 32'h0000_1234; ro_set[1] = 32'hA5A5_0001; ro_set[2] = 32'h0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_start", 32'(acc_start), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < NRW; i++) chk("rst_rw", rw_set[i], 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    wr_en = 1'b1; #1;
    chk("rst_ready_wr", 32'(req_ready), 32'd1);
    wr_en = 1'b0;

    // Write then read back a config register
    wr(4'd1, 32'hDEAD_BEEF);
    chk("wr_rw1", rw_set[1], 32'hDEAD_BEEF);
    chk("wr_rw0", rw_set[0], 32'd0);
    chk("wr_no_rsp", 32'(rsp_valid), 32'd0);
    chk("wr_no_start", 32'(acc_start), 32'd0);
    rd("rd_rw1", 4'd1, 32'hDEAD_BEEF, 1'b0);

    // Response held under backpressure
    addr = 4'd1; wr_en = 1'b0; req_valid = 1'b1; rsp_ready = 1'b0;
    #1;
    wait_ready("hold_ready");
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("hold_vld0", 32'(rsp_valid), 32'd1);
    chk("hold_dat0", rd_data, 32'hDEAD_BEEF);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("hold_vld", 32'(rsp_valid), 32'd1);
      chk("hold_dat", rd_data, 32'hDEAD_BEEF);
      chk("hold_rdy", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold_done_vld", 32'(rsp_valid), 32'd0);
    chk("hold_done_rdy", 32'(req_ready), 32'd1);

    // Start, write stall while busy, concurrent CTRL read, busy count
    wr(CTRL, 32'd1);
    chk("start_pulse", 32'(acc_start), 32'd1);
    wr_en = 1'b1; #1;
    chk("start_q_stall", 32'(req_ready), 32'd0);
    acc_busy = 1'b1;
    addr = 4'd0; wdata = 32'd5; req_valid = 1'b1;
    #1;
    chk("busy_wr_rdy", 32'(req_ready), 32'd0);
    @(posedge clk); #1;                          // busy edge 1
    chk("start_once", 32'(acc_start), 32'd0);
    chk("busy_wr_blocked", rw_set[0], 32'd0);
    wr_en = 1'b0; addr = CTRL; #1;
    chk("busy_rd_rdy", 32'(req_ready), 32'd1);
    @(posedge clk); #1;                          // busy edge 2, read accepted
    req_valid = 1'b0;
    chk("busy_ctrl_vld", 32'(rsp_valid), 32'd1);
    chk("busy_ctrl_rd", rd_data, 32'h1);
    @(posedge clk); #1;                          // busy edge 3, handshake
    chk("busy_ctrl_hs", 32'(rsp_valid), 32'd0);
    repeat (7) @(posedge clk);                   // busy edges 4..10
    #1;
    acc_busy = 1'b0;
    @(posedge clk); #1;
    rd("busycnt10", BCNT, 32'd10, 1'b0);
    chk("busy_rw0_final", rw_set[0], 32'd0);

    // Sticky done, including done coinciding with the clearing read
    acc_done = 1'b1;
    @(posedge clk); #1;
    acc_done = 1'b0;
    rd("done_rd1", CTRL, 32'h2, 1'b0);
    rd("done_rd2", CTRL, 32'h0, 1'b0);
    acc_done = 1'b1;
    @(posedge clk); #1;
    acc_done = 1'b0;
    rd("done_race1", CTRL, 32'h2, 1'b1);
    rd("done_race2", CTRL, 32'h2, 1'b0);
    rd("done_race3", CTRL, 32'h0, 1'b0);

    // RO registers, out-of-range, ignored writes
    rd("ro0", 4'd4, 32'h0000_1234, 1'b0);
    rd("ro1", 4'd5, 32'hA5A5_0001, 1'b0);
    rd("oor_tot", TOT, 32'd0, 1'b0);
    rd("oor_15", 4'd15, 32'd0, 1'b0);
    wr(4'd4, 32'hFFFF_FFFF);
    wr(BCNT, 32'd0);
    wr(4'd12, 32'h1111_2222);
    rd("ro0_after_wr", 4'd4, 32'h0000_1234, 1'b0);
    rd("bcnt_after_wr", BCNT, 32'd10, 1'b0);
    chk("oor_wr_rw0", rw_set[0], 32'd0);
    chk("oor_wr_rw1", rw_set[1], 32'hDEAD_BEEF);
    chk("oor_wr_rw2", rw_set[2], 32'd0);
    chk("oor_wr_rw3", rw_set[3], 32'd0);
    wr(CTRL, 32'h2);
    chk("ctrl0_no_start", 32'(acc_start), 32'd0);
    wr_en = 1'b1; #1;
    chk("ctrl0_no_stall", 32'(req_ready), 32'd1);
    wr_en = 1'b0;

    // A new start clears the busy counter
    wr(CTRL, 32'd1);
    chk("start2_pulse", 32'(acc_start), 32'd1);
    acc_busy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    acc_busy = 1'b0;
    rd("busycnt3", BCNT, 32'd3, 1'b0);

    // Reset with a pending response, then reset right after a start write
    wr(4'd2, 32'h55);
    addr = 4'd2; wr_en = 1'b0; req_valid = 1'b1; rsp_ready = 1'b0;
    #1;
    wait_ready("mid_ready");
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("mid_pending", 32'(rsp_valid), 32'd1);
    chk("mid_pending_dat", rd_data, 32'h55);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mid_rsp_drop", 32'(rsp_valid), 32'd0);
    for (int i = 0; i < NRW; i++) chk("mid_rw", rw_set[i], 32'd0);
    rsp_ready = 1'b1;
    wr(CTRL, 32'd1);
    chk("mid_start", 32'(acc_start), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mid_start_cancel", 32'(acc_start), 32'd0);
    wr_en = 1'b1; #1;
    chk("mid_start_q_clr", 32'(req_ready), 32'd1);
    wr_en = 1'b0;
    rd("mid_bcnt", BCNT, 32'd0, 1'b0);
    rd("mid_rw2", 4'd2, 32'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/csr_reg_manager.md
# csr_reg_manager

Accelerator-side CSR endpoint that terminates one output port of the CSR demux and holds the accelerator's configuration registers. It stores read-write configuration CSRs and exposes read-only status CSRs from the datapath. It issues a one-cycle start pulse, tracks busy/done status and counts busy cycles. Only one request is outstanding at a time, and writes are stalled while the accelerator is running.

## Interface
- NumRwCsr, 4, number of read-write configuration registers (addresses 0..NumRwCsr-1)
- NumRoCsr, 2, number of read-only datapath registers (addresses NumRwCsr..NumRwCsr+NumRoCsr-1)
- RegDataWidth, 32, CSR data width
- TotalRegCount, NumRwCsr+NumRoCsr+2, derived; includes the control/status register and the busy counter
- RegAddrWidth, $clog2(TotalRegCount), derived

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, synchronous, active-low
- csr_addr_i  in  RegAddrWidth  request address
- csr_wr_data_i  in  RegDataWidth  write data
- csr_wr_en_i  in  1  1 = write, 0 = read
- csr_req_valid_i  in  1  request valid
- csr_req_ready_o  out  1  request ready
- csr_rd_data_o  out  RegDataWidth  read response data
- csr_rsp_valid_o  out  1  read response valid
- csr_rsp_ready_i  in  1  response ready
- csr_reg_rw_set_o  out  NumRwCsr x RegDataWidth  configuration registers
- csr_reg_ro_set_i  in  NumRoCsr x RegDataWidth  datapath status values
- acc_start_o  out  1  start pulse
- acc_busy_i  in  1  accelerator running
- acc_done_i  in  1  completion pulse

## Operation
- Address map:
  - RW registers occupy 0..NumRwCsr-1.
  - RO registers follow at NumRwCsr..NumRwCsr+NumRoCsr-1.
  - CTRL = NumRwCsr+NumRoCsr.
  - BUSYCNT = CTRL+1.
  - All addresses at or above TotalRegCount are out of range.
- A request is accepted on the cycle where csr_req_valid_i and csr_req_ready_o are both high.
- csr_req_ready_o = !rsp_valid_q && !(csr_wr_en_i && busy).
  - busy = acc_busy_i || start_q.
  - Reads are never blocked by busy; writes are.
- Write:
  - RW address: the register updates on the accept edge.
  - CTRL address with wr_data[0]=1: start_q is set and acc_start_o pulses for exactly one cycle. The same write clears BUSYCNT.
  - CTRL address with wr_data[0]=0, RO, BUSYCNT or out-of-range addresses: the write is ignored.
  - Writes never produce a response.
- Read:
  - Data is captured on the accept edge into rd_data_q.
  - rsp_valid_q is set on the same edge and held, with stable data, until csr_rsp_ready_i is high.
  - CTRL reads return {0.., done_sticky, busy}.
  - Out-of-range reads return 0.
- done_sticky:
  - Set by acc_done_i.
  - Cleared by an accepted read of CTRL.
  - If set and clear happen in the same cycle, set wins and the read returns the pre-update value.
- start_q is cleared on the first cycle acc_busy_i is high. This covers the gap until the accelerator raises busy.
- BUSYCNT increments on every cycle acc_busy_i is high and saturates at all-ones.

## Timing
- Reset values:
  - All RW registers, rd_data_q, done_sticky, start_q and BUSYCNT are 0.
  - csr_rsp_valid_o=0, acc_start_o=0.
  - csr_req_ready_o is combinational: 1 after reset unless a write is presented while acc_busy_i is high.
- Read latency: request accepted in cycle N, response valid in cycle N+1.
- Read throughput: at most one read every 2 cycles. A new request can be accepted only in the cycle after the response handshake.
- Write effect: visible on csr_reg_rw_set_o in cycle N+1. acc_start_o is high in cycle N+1 only.
- csr_rsp_valid_o and csr_rd_data_o are registered outputs. csr_req_ready_o is combinational from csr_wr_en_i and acc_busy_i.
- Reset mid-operation: a pending response is dropped, the start pulse is cancelled, and all registers return to reset values on the next edge.
- The write stall starts with the cycle after the start write (start_q) and lasts until acc_busy_i falls.

## Structure
- Shared package csr_mgr_pkg holds:
  - address offset functions/constants (CTRL, BUSYCNT relative to NumRwCsr+NumRoCsr);
  - CTRL bit indices (BUSY_BIT=0, DONE_BIT=1, START_BIT=0 on write).
- One sub-module: csr_sat_counter, a parameterised-width saturating counter with inc and clear inputs, used for BUSYCNT.

## Test plan
- Write 0xDEADBEEF to addr 1, then read addr 1 → csr_reg_rw_set_o[1]=0xDEADBEEF one cycle after accept; read response 0xDEADBEEF one cycle after accept.
- Hold csr_rsp_ready_i=0 for 5 cycles after a read → rsp_valid stays 1, data stable, csr_req_ready_o=0; handshake completes when ready rises.
- Write 1 to CTRL; hold acc_busy_i high for 10 cycles → acc_start_o is a single pulse; a write attempted while busy sees ready=0; a concurrent CTRL read returns bit0=1; BUSYCNT reads 10 afterward.
- Pulse acc_done_i, then read CTRL twice → first read returns 0x2, second returns 0x0. Repeat with acc_done_i coinciding with the read accept → second read still returns 0x2.
- Read RO addr with csr_reg_ro_set_i[0]=0x1234; read address TotalRegCount; write to RO → returns 0x1234, returns 0, RO value unaffected.
- Assert rst_ni=0 with a response pending and after a start write → next cycle rsp_valid=0, acc_start_o=0, all RW regs 0.
